rr_mux4x1_stream: RTL and testbench

- Registered 4-to-1 stream multiplexer: the combining counterpart of the 1x4 demux.
- Four valid/ready input lanes are arbitrated round-robin onto one output stream.
- Arbitration is locked per packet, so a packet is never interleaved with another lane.
- out_sel carries the source lane index, so a downstream 1x4 demux can route beats back to the lane selected by {s1,s2} = out_sel.

---
 rtl/rr_mux4x1_stream_pkg.sv | 25 ++
 rtl/rr_arb4.sv | 37 +++
 rtl/rr_mux4x1_stream.sv | 124 ++++++++++++
 tb/tb_rr_mux4x1_stream.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux4x1_stream_pkg.sv
// ============================================================================
// Module   : rr_mux4x1_stream_pkg
// Brief    : Shared types for the round-robin 4:1 stream mux and its arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rr_mux4x1_stream_pkg;

    localparam int NUM_LANES = 4;

    typedef logic [1:0] lane_idx_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    function automatic lane_idx_t next_lane(input lane_idx_t lane);
        return lane_idx_t'(lane + 2'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb4.sv
// ============================================================================
// Module   : rr_arb4
// Brief    : Combinational 4-way rotating-priority arbiter; ptr has top priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb4
    import rr_mux4x1_stream_pkg::*;
(
    input  logic [NUM_LANES-1:0] req,
    input  lane_idx_t            ptr,
    output logic [NUM_LANES-1:0] gnt,
    output lane_idx_t            gnt_idx
);

    lane_idx_t w_cand;

    // Scan from lowest priority to highest so the closest requester to ptr wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        w_cand  = ptr;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            w_cand = lane_idx_t'(ptr + lane_idx_t'(k));
            if (req[w_cand]) begin
                gnt_idx = w_cand;
            end
        end
        if (|req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_mux4x1_stream.sv
// ============================================================================
// Module   : rr_mux4x1_stream
// Brief    : Registered 4:1 valid/ready stream mux, round-robin, packet-locked.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_mux4x1_stream
    import rr_mux4x1_stream_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LOCK_EN = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_LANES-1:0]       in_valid,
    input  logic [NUM_LANES*WIDTH-1:0] in_data,
    input  logic [NUM_LANES-1:0]       in_last,
    output logic [NUM_LANES-1:0]       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_last,
    output logic [1:0]                 out_sel,
    input  logic                       out_ready
);

    state_t          r_state;
    state_t          w_state_nxt;
    lane_idx_t       r_ptr;
    lane_idx_t       w_ptr_nxt;
    lane_idx_t       r_lock_lane;
    lane_idx_t       w_lock_nxt;
    logic            r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic            r_out_last;
    lane_idx_t       r_out_sel;

    logic [WIDTH-1:0]     w_lane_data [NUM_LANES];
    logic [NUM_LANES-1:0] w_rr_gnt;
    lane_idx_t            w_rr_idx;
    logic [NUM_LANES-1:0] w_grant;
    lane_idx_t            w_grant_idx;
    logic                 w_load_ok;
    logic                 w_xfer;

    genvar gi;
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        assign w_lane_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end

    rr_arb4 u_arb (
        .req     (in_valid),
        .ptr     (r_ptr),
        .gnt     (w_rr_gnt),
        .gnt_idx (w_rr_idx)
    );

    assign w_load_ok = !r_out_valid || out_ready;

    always_comb begin
        w_grant     = '0;
        w_grant_idx = w_rr_idx;
        if (r_state == LOCK) begin
            w_grant[r_lock_lane] = in_valid[r_lock_lane];
            w_grant_idx          = r_lock_lane;
        end else begin
            w_grant = w_rr_gnt;
        end
    end

    assign in_ready = (rst || !w_load_ok) ? '0 : w_grant;
    assign w_xfer   = |in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock_lane;
        if (w_xfer) begin
            if (LOCK_EN == 0) begin
                w_state_nxt = IDLE;
                w_ptr_nxt   = next_lane(w_grant_idx);
            end else if (in_last[w_grant_idx]) begin
                // End of packet (or single-beat packet): release and rotate.
                w_state_nxt = IDLE;
                w_ptr_nxt   = next_lane(w_grant_idx);
            end else begin
                w_state_nxt = LOCK;
                w_lock_nxt  = w_grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_lock_lane <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_lock_lane <= w_lock_nxt;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_lane_data[w_grant_idx];
                r_out_last  <= in_last[w_grant_idx];
                r_out_sel   <= w_grant_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux4x1_stream.sv
// ============================================================================
// Module   : tb_rr_mux4x1_stream
// Brief    : Directed self-checking bench for rr_mux4x1_stream (locked and unlocked).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_mux4x1_stream;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     in_valid;
    logic [4*W-1:0] in_data;
    logic [3:0]     in_last;
    logic           out_ready;

    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic [1:0]   out_sel;

    logic [3:0]   nl_in_ready;
    logic         nl_out_valid;
    logic [W-1:0] nl_out_data;
    logic         nl_out_last;
    logic [1:0]   nl_out_sel;

    int n_asserts = 0;
    int n_fails   = 0;

    always #5 clk = ~clk;

    rr_mux4x1_stream #(.WIDTH(W), .LOCK_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    rr_mux4x1_stream #(.WIDTH(W), .LOCK_EN(0)) dut_nl (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(nl_in_ready), .out_valid(nl_out_valid), .out_data(nl_out_data),
        .out_last(nl_out_last), .out_sel(nl_out_sel), .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [W-1:0] d);
        in_data[i*W +: W] = d;
    endtask

    // Advance one clock; verify held outputs across a stalled edge and one-hot ready.
    task automatic tick();
        logic         hold;
        logic [W-1:0] hd;
        logic [1:0]   hs;
        logic         hl;
        hold = out_valid && !out_ready && !rst;
        hd = out_data;
        hs = out_sel;
        hl = out_last;
        @(posedge clk);
        #1;
        if (hold) begin
            check("stall_data", 32'(out_data), 32'(hd));
            check("stall_sel",  32'(out_sel),  32'(hs));
            check("stall_last", 32'(out_last), 32'(hl));
        end
        check("onehot0_ready",    32'($onehot0(in_ready)),    32'd1);
        check("onehot0_nl_ready", 32'($onehot0(nl_in_ready)), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        out_ready = 1'b1;
        in_data   = '0;
        for (int i = 0; i < 4; i++) set_lane(i, 8'hA0 + 8'(i));

        // Reset held two cycles with every lane requesting
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'h0);
        check("rst_out_sel",   32'(out_sel),   32'd0);
        rst = 1'b0;
        #1;
        check("first_grant", 32'(in_ready), 32'b0001);
        check("pre_out_valid", 32'(out_valid), 32'd0);

        // Round robin over single-beat packets
        for (int k = 0; k < 6; k++) begin
            tick();
            check("rr_valid", 32'(out_valid), 32'd1);
            check("rr_sel",   32'(out_sel),   32'(k % 4));
            check("rr_data",  32'(out_data),  32'(8'hA0 + 8'(k % 4)));
            check("rr_last",  32'(out_last),  32'd1);
            #1;
            check("rr_ready", 32'(in_ready), 32'(4'b0001 << ((k + 1) % 4)));
        end

        // Packet lock on lane 2 while lanes 0 and 1 compete
        in_valid = 4'b0111;
        in_last  = 4'b0000;
        set_lane(0, 8'hB0);
        set_lane(1, 8'hB1);
        set_lane(2, 8'h11);
        #1;
        check("lock_ready0", 32'(in_ready), 32'b0100);
        tick();
        check("lock_data0", 32'(out_data), 32'h11);
        check("lock_sel0",  32'(out_sel),  32'd2);
        check("lock_last0", 32'(out_last), 32'd0);
        set_lane(2, 8'h22);
        #1;
        check("lock_ready1", 32'(in_ready), 32'b0100);
        tick();
        check("lock_data1", 32'(out_data), 32'h22);
        check("lock_sel1",  32'(out_sel),  32'd2);
        set_lane(2, 8'h33);
        in_last = 4'b0100;
        #1;
        check("lock_ready2", 32'(in_ready), 32'b0100);
        tick();
        check("lock_data2", 32'(out_data), 32'h33);
        check("lock_sel2",  32'(out_sel),  32'd2);
        check("lock_last2", 32'(out_last), 32'd1);
        in_valid = 4'b0011;
        set_lane(0, 8'h5A);
        in_last = 4'b0001;
        #1;
        check("post_lock_grant", 32'(in_ready), 32'b0001);

        // Backpressure with 5A held
        tick();
        check("bp_data", 32'(out_data), 32'h5A);
        check("bp_sel",  32'(out_sel),  32'd0);
        out_ready = 1'b0;
        set_lane(1, 8'hC1);
        in_last = 4'b0011;
        #1;
        check("bp_ready", 32'(in_ready), 32'h0);
        repeat (4) begin
            tick();
            check("bp_hold_valid", 32'(out_valid), 32'd1);
            check("bp_hold_data",  32'(out_data),  32'h5A);
            check("bp_hold_ready", 32'(in_ready),  32'h0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'b0010);
        tick();
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_data",  32'(out_data),  32'hC1);
        check("bp_next_sel",   32'(out_sel),   32'd1);
        in_valid = 4'b0000;
        #1;
        check("idle_ready", 32'(in_ready), 32'h0);
        tick();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_data",  32'(out_data),  32'hC1);

        // Lock starvation on lane 1, then reset releases it
        in_valid = 4'b0010;
        set_lane(1, 8'hD1);
        in_last = 4'b0000;
        #1;
        check("starve_grant", 32'(in_ready), 32'b0010);
        tick();
        check("starve_data", 32'(out_data), 32'hD1);
        check("starve_sel",  32'(out_sel),  32'd1);
        in_valid = 4'b1000;
        set_lane(3, 8'hE3);
        in_last = 4'b1000;
        #1;
        check("starve_ready0", 32'(in_ready), 32'h0);
        repeat (3) begin
            tick();
            check("starve_ready", 32'(in_ready), 32'h0);
        end
        check("starve_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick();
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("rst2_grant", 32'(in_ready), 32'b1000);
        tick();
        check("rst2_data", 32'(out_data), 32'hE3);
        check("rst2_sel",  32'(out_sel),  32'd3);

        // Unlocked instance interleaves two 2-beat packets
        in_valid = 4'b0011;
        set_lane(0, 8'h40);
        set_lane(1, 8'h50);
        in_last = 4'b0000;
        #1;
        check("nl_ready0", 32'(nl_in_ready), 32'b0001);
        tick();
        check("nl_data0", 32'(nl_out_data), 32'h40);
        check("nl_sel0",  32'(nl_out_sel),  32'd0);
        check("nl_last0", 32'(nl_out_last), 32'd0);
        set_lane(0, 8'h41);
        in_last = 4'b0001;
        #1;
        check("nl_ready1",     32'(nl_in_ready), 32'b0010);
        check("locked_ready1", 32'(in_ready),    32'b0001);
        tick();
        check("nl_data1", 32'(nl_out_data), 32'h50);
        check("nl_sel1",  32'(nl_out_sel),  32'd1);
        check("nl_last1", 32'(nl_out_last), 32'd0);
        set_lane(1, 8'h51);
        in_last = 4'b0011;
        #1;
        check("nl_ready2", 32'(nl_in_ready), 32'b0001);
        tick();
        check("nl_data2", 32'(nl_out_data), 32'h41);
        check("nl_sel2",  32'(nl_out_sel),  32'd0);
        check("nl_last2", 32'(nl_out_last), 32'd1);
        in_valid = 4'b0010;
        #1;
        check("nl_ready3", 32'(nl_in_ready), 32'b0010);
        tick();
        check("nl_data3", 32'(nl_out_data), 32'h51);
        check("nl_sel3",  32'(nl_out_sel),  32'd1);
        check("nl_last3", 32'(nl_out_last), 32'd1);
        in_valid = 4'b0000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
